// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// timeout default, memory-command widths and the command payload.
package data_mem_arbiter_pkg;

    localparam int unsigned ADDR_W            = 32;
    localparam int unsigned DATA_W            = 32;
    localparam int unsigned MASK_W            = 4;
    localparam int unsigned CNT_W             = 4;
    localparam int unsigned STALL_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE,
        RD_STALL,
        RD_DATA,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] mask;
    } mem_cmd_t;

    // A request flagged as both read and write is issued as a write only.
    function automatic mem_cmd_t make_cmd(
        input logic              read,
        input logic              write,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata,
        input logic [MASK_W-1:0] mask
    );
        mem_cmd_t c;
        c.read  = read & ~write;
        c.write = write;
        c.addr  = addr;
        c.wdata = wdata;
        c.mask  = mask;
        return c;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_grant.sv
// Two-way grant selection: fixed priority to requester 0, or round-robin
// with a pointer register when DATA_MEM_ARB_RR_EN is defined.
module arb2_grant (
`ifdef DATA_MEM_ARB_RR_EN
    input  logic       clk,
    input  logic       reset,
    input  logic       take,
`endif
    input  logic [1:0] req,
    output logic       idx
);

`ifdef DATA_MEM_ARB_RR_EN
    logic ptr;

    // Ties go to the pointer; it moves past whoever was granted.
    assign idx = req[1] & (~req[0] | ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (take) begin
            ptr <= ~idx;
        end
    end
`else
    assign idx = req[1] & ~req[0];
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto one data-memory port and tracks reads
// through the memory stall handshake with a timeout. Optional round-robin
// arbitration is enabled by defining DATA_MEM_ARB_RR_EN.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [MASK_W-1:0] req0_sign_mask,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_rerr,
    input  logic              req1_valid,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [MASK_W-1:0] req1_sign_mask,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_rerr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic [MASK_W-1:0] mem_sign_mask,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_clk_stall
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(STALL_TIMEOUT - 1);

    arb_state_e       state, state_n;
    logic [CNT_W-1:0] wait_cnt;
    logic             owner;
    logic [1:0]       eligible;
    logic             gnt_idx;
    logic             grant, cnt_clr, resp_go, resp_err, timeout;
    mem_cmd_t         cmd0, cmd1, cmd;

    assign cmd0 = make_cmd(req0_read, req0_write, req0_addr, req0_wdata, req0_sign_mask);
    assign cmd1 = make_cmd(req1_read, req1_write, req1_addr, req1_wdata, req1_sign_mask);
    assign eligible = {req1_valid & (cmd1.read | cmd1.write),
                       req0_valid & (cmd0.read | cmd0.write)};
    assign timeout  = (wait_cnt == WAIT_LAST);

    arb2_grant u_grant (
`ifdef DATA_MEM_ARB_RR_EN
        .clk   (clk),
        .reset (reset),
        .take  (grant),
`endif
        .req   (eligible),
        .idx   (gnt_idx)
    );

    // Next-state and grant-cycle command selection.
    always_comb begin
        state_n  = state;
        grant    = 1'b0;
        cnt_clr  = 1'b0;
        resp_go  = 1'b0;
        resp_err = 1'b0;
        cmd      = '0;
        case (state)
            IDLE: begin
                if (!mem_clk_stall && (eligible != 2'b00)) begin
                    grant = 1'b1;
                    cmd   = gnt_idx ? cmd1 : cmd0;
                    if (cmd.read) begin
                        state_n = RD_STALL;
                        cnt_clr = 1'b1;
                    end
                end
            end
            RD_STALL: begin
                if (mem_clk_stall) begin
                    state_n = RD_DATA;
                    cnt_clr = 1'b1;
                end else if (timeout) begin
                    state_n  = RESP;
                    resp_go  = 1'b1;
                    resp_err = 1'b1;
                end
            end
            RD_DATA: begin
                if (!mem_clk_stall) begin
                    state_n = RESP;
                    resp_go = 1'b1;
                end else if (timeout) begin
                    state_n  = RESP;
                    resp_go  = 1'b1;
                    resp_err = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr       = cmd.addr;
    assign mem_write_data = cmd.wdata;
    assign mem_sign_mask  = cmd.mask;
    assign mem_memread    = cmd.read;
    assign mem_memwrite   = cmd.write;
    assign req0_ready     = grant & ~gnt_idx;
    assign req1_ready     = grant & gnt_idx;

    // Response registers are loaded on entry to RESP and hold rdata afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            owner       <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rerr   <= 1'b0;
            req1_rerr   <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            state <= state_n;
            if (cnt_clr) begin
                wait_cnt <= '0;
            end else if ((state == RD_STALL) || (state == RD_DATA)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (grant && cmd.read) begin
                owner <= gnt_idx;
            end
            req0_rvalid <= resp_go & ~owner;
            req1_rvalid <= resp_go & owner;
            req0_rerr   <= resp_go & ~owner & resp_err;
            req1_rerr   <= resp_go & owner & resp_err;
            if (resp_go && !owner) begin
                req0_rdata <= resp_err ? '0 : mem_read_data;
            end
            if (resp_go && owner) begin
                req1_rdata <= resp_err ? '0 : mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model of the arbiter.
module tb_data_mem_arbiter;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       v = '0, rd = '0, wr = '0;
    logic [1:0][31:0] ad = '0, wd = '0;
    logic [1:0][3:0]  sm = '0;
    logic [1:0]       rdy, rv, rerr;
    logic [1:0][31:0] rdat;
    logic [31:0]      mem_addr, mem_write_data, mem_read_data;
    logic             mem_memread, mem_memwrite, mem_clk_stall;
    logic [3:0]       mem_sign_mask;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (v[0]),
        .req0_read      (rd[0]),
        .req0_write     (wr[0]),
        .req0_addr      (ad[0]),
        .req0_wdata     (wd[0]),
        .req0_sign_mask (sm[0]),
        .req0_ready     (rdy[0]),
        .req0_rvalid    (rv[0]),
        .req0_rdata     (rdat[0]),
        .req0_rerr      (rerr[0]),
        .req1_valid     (v[1]),
        .req1_read      (rd[1]),
        .req1_write     (wr[1]),
        .req1_addr      (ad[1]),
        .req1_wdata     (wd[1]),
        .req1_sign_mask (sm[1]),
        .req1_ready     (rdy[1]),
        .req1_rvalid    (rv[1]),
        .req1_rdata     (rdat[1]),
        .req1_rerr      (rerr[1]),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    // Memory model: stalls stall_len cycles after each read (0 = never stalls).
    bit [31:0]   memory [256];
    bit          written [256];
    int unsigned stall_len = 1;
    int unsigned pend = 0;
    logic        force_stall = 1'b0;
    logic [31:0] rd_data_q = '0;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_1234);
    endfunction

    always @(posedge clk) begin
        if (mem_memwrite) begin
            memory[mem_addr[9:2]]  <= mem_write_data;
            written[mem_addr[9:2]] <= 1'b1;
        end
        if (mem_memread) begin
            pend      <= stall_len;
            rd_data_q <= written[mem_addr[9:2]] ? memory[mem_addr[9:2]] : fill(mem_addr);
        end else if (pend != 0) begin
            pend <= pend - 1;
        end
    end

    assign mem_clk_stall = force_stall || (pend != 0);
    assign mem_read_data = rd_data_q;

    task automatic idle_inputs();
        v = '0; rd = '0; wr = '0; ad = '0; wd = '0; sm = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        force_stall = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) next_cycle();
        @(negedge clk);
        vecs++;
        if (rdy !== 2'b00 || rv !== 2'b00 || rerr !== 2'b00) begin
            errs++;
            $display("FAIL reset_flags: ready=%b rvalid=%b rerr=%b want all 0", rdy, rv, rerr);
        end
        vecs++;
        if (rdat[0] !== 32'h0 || rdat[1] !== 32'h0) begin
            errs++;
            $display("FAIL reset_rdata: rdata0=%h rdata1=%h want 0", rdat[0], rdat[1]);
        end
        vecs++;
        if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0 || mem_addr !== 32'h0 ||
            mem_write_data !== 32'h0 || mem_sign_mask !== 4'h0) begin
            errs++;
            $display("FAIL reset_mem: rd=%b wr=%b addr=%h wdata=%h mask=%h want 0",
                     mem_memread, mem_memwrite, mem_addr, mem_write_data, mem_sign_mask);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        stall_len = 1;
        v[0] = 1'b1; rd[0] = 1'b1; ad[0] = 32'h10; sm[0] = 4'hF;
        @(negedge clk);
        vecs++;
        if (rdy !== 2'b01 || mem_memread !== 1'b1 || mem_memwrite !== 1'b0 ||
            mem_addr !== 32'h10 || mem_sign_mask !== 4'hF) begin
            errs++;
            $display("FAIL single_read_grant: ready=%b rd=%b wr=%b addr=%h mask=%h want 01 1 0 10 f",
                     rdy, mem_memread, mem_memwrite, mem_addr, mem_sign_mask);
        end
        next_cycle();
        idle_inputs();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vecs++;
            if (rv !== ((c == 3) ? 2'b01 : 2'b00) || rdy !== 2'b00 || mem_memread !== 1'b0) begin
                errs++;
                $display("FAIL single_read_t%0d: rvalid=%b ready=%b memread=%b", c, rv, rdy, mem_memread);
            end
            if (c >= 3) begin
                vecs++;
                if (rdat[0] !== 32'hDEAD_BEEF || rerr !== 2'b00) begin
                    errs++;
                    $display("FAIL single_read_data_t%0d: rdata=%h rerr=%b want deadbeef 00", c, rdat[0], rerr);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_write_contention();
        int   k [2];
        logic g;
        apply_reset();
        k[0] = 0; k[1] = 0;
        for (int c = 0; c < 4; c++) begin
            for (int n = 0; n < 2; n++) begin
                v[n] = 1'b1; wr[n] = 1'b1; rd[n] = 1'b0; sm[n] = 4'h3;
                ad[n] = 32'h200 + 32'(n * 64) + 32'(k[n] * 4);
                wd[n] = 32'hA000_0000 + 32'(n * 256) + 32'(k[n]);
            end
`ifdef DATA_MEM_ARB_RR_EN
            g = ((c % 2) == 1);
`else
            g = 1'b0;
`endif
            @(negedge clk);
            vecs++;
            if (rdy !== (g ? 2'b10 : 2'b01) || mem_memwrite !== 1'b1 || mem_memread !== 1'b0) begin
                errs++;
                $display("FAIL contention_grant_c%0d: ready=%b wr=%b rd=%b want grant %0d",
                         c, rdy, mem_memwrite, mem_memread, g);
            end
            vecs++;
            if (mem_addr !== ad[g] || mem_write_data !== wd[g] || mem_sign_mask !== 4'h3) begin
                errs++;
                $display("FAIL contention_cmd_c%0d: addr=%h wdata=%h want %h %h",
                         c, mem_addr, mem_write_data, ad[g], wd[g]);
            end
            k[g]++;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_read_blocks_write();
        stall_len = 1;
        v[1] = 1'b1; rd[1] = 1'b1; ad[1] = 32'h20;
        @(negedge clk);
        vecs++;
        if (rdy !== 2'b10 || mem_memread !== 1'b1 || mem_addr !== 32'h20) begin
            errs++;
            $display("FAIL blocking_read_grant: ready=%b rd=%b addr=%h want 10 1 20", rdy, mem_memread, mem_addr);
        end
        next_cycle();
        idle_inputs();
        v[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h300; wd[0] = 32'h1234_5678; sm[0] = 4'hF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vecs++;
            if (c < 4 && (rdy !== 2'b00 || mem_memwrite !== 1'b0)) begin
                errs++;
                $display("FAIL blocking_hold_t%0d: ready=%b wr=%b want 00 0", c, rdy, mem_memwrite);
            end else if (c == 4 && (rdy !== 2'b01 || mem_memwrite !== 1'b1 || mem_addr !== 32'h300)) begin
                errs++;
                $display("FAIL blocking_release: ready=%b wr=%b addr=%h want 01 1 300", rdy, mem_memwrite, mem_addr);
            end
            if (c == 3) begin
                vecs++;
                if (rv !== 2'b10 || rdat[1] !== fill(32'h20) || rerr !== 2'b00) begin
                    errs++;
                    $display("FAIL blocking_resp: rvalid=%b rdata1=%h rerr=%b want 10 %h 00",
                             rv, rdat[1], rerr, fill(32'h20));
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        stall_len = 0;
        v[0] = 1'b1; rd[0] = 1'b1; ad[0] = 32'h40;
        @(negedge clk);
        vecs++;
        if (rdy !== 2'b01 || mem_memread !== 1'b1) begin
            errs++;
            $display("FAIL timeout_grant: ready=%b rd=%b want 01 1", rdy, mem_memread);
        end
        next_cycle();
        idle_inputs();
        v[1] = 1'b1; wr[1] = 1'b1; ad[1] = 32'h340; wd[1] = 32'hCAFE_0001; sm[1] = 4'h1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c < 16) begin
                if (rv !== 2'b00 || rdy !== 2'b00) begin
                    errs++;
                    $display("FAIL timeout_wait_t%0d: rvalid=%b ready=%b want 00 00", c, rv, rdy);
                end
            end else if (c == 16) begin
                vecs++;
                if (rv !== 2'b01 || rerr !== 2'b01 || rdat[0] !== 32'h0 || rdy !== 2'b00) begin
                    errs++;
                    $display("FAIL timeout_resp: rvalid=%b rerr=%b rdata0=%h ready=%b want 01 01 0 00",
                             rv, rerr, rdat[0], rdy);
                end
            end else begin
                vecs++;
                if (rdy !== 2'b10 || mem_memwrite !== 1'b1 || rv !== 2'b00 || rerr !== 2'b00) begin
                    errs++;
                    $display("FAIL timeout_idle: ready=%b wr=%b rvalid=%b rerr=%b want 10 1 00 00",
                             rdy, mem_memwrite, rv, rerr);
                end
            end
            next_cycle();
        end
        vecs++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        stall_len = 0;
        force_stall = 1'b0;
        v[0] = 1'b1; rd[0] = 1'b1; ad[0] = 32'h50;
        @(negedge clk);
        vecs++;
        if (rdy !== 2'b01 || mem_memread !== 1'b1) begin
            errs++;
            $display("FAIL rstread_grant: ready=%b rd=%b want 01 1", rdy, mem_memread);
        end
        next_cycle();
        idle_inputs();
        force_stall = 1'b1;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        v[1] = 1'b1; wr[1] = 1'b1; ad[1] = 32'h380; wd[1] = 32'h0BAD_F00D;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vecs++;
            if (rv !== 2'b00 || rerr !== 2'b00 || rdat[0] !== 32'h0 || rdat[1] !== 32'h0 ||
                rdy !== 2'b00 || mem_memwrite !== 1'b0) begin
                errs++;
                $display("FAIL rstread_quiet_c%0d: rvalid=%b rerr=%b rdata=%h/%h ready=%b wr=%b want all 0",
                         c, rv, rerr, rdat[0], rdat[1], rdy, mem_memwrite);
            end
            next_cycle();
        end
        force_stall = 1'b0;
        @(negedge clk);
        vecs++;
        if (rdy !== 2'b10 || mem_memwrite !== 1'b1 || mem_addr !== 32'h380) begin
            errs++;
            $display("FAIL rstread_resume: ready=%b wr=%b addr=%h want 10 1 380", rdy, mem_memwrite, mem_addr);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_random();
        bit [31:0]        ref_mem [16];
        bit               ref_wr [16];
        logic [1:0][31:0] held;
        logic [1:0]       elig, exp_rdy, exp_rv, exp_err;
        logic             g, g_any, is_wr, is_rd, owner_m, err_m, ptr_m;
        logic [31:0]      data_m, exp_addr, exp_wdata;
        logic [3:0]       exp_mask;
        int               busy, r;
        int unsigned      kind;
        apply_reset();
        held = '0; busy = 0; owner_m = 1'b0; err_m = 1'b0; data_m = '0; ptr_m = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!v[n] && $urandom_range(0, 2) != 0) begin
                    kind  = $urandom_range(0, 2);
                    v[n]  = 1'b1;
                    rd[n] = (kind != 1);
                    wr[n] = (kind != 0);
                    ad[n] = 32'h100 + 32'($urandom_range(0, 15) * 4);
                    wd[n] = $urandom;
                    sm[n] = 4'($urandom_range(0, 15));
                end
            end
            r = int'($urandom_range(0, 9));
            stall_len = (r == 0) ? 0 : ((r == 9) ? 20 : r);
            @(negedge clk);
            elig  = v & (rd | wr);
            g_any = (busy == 0) && !mem_clk_stall && (elig != 2'b00);
`ifdef DATA_MEM_ARB_RR_EN
            g = (elig == 2'b11) ? ptr_m : elig[1];
`else
            g = elig[1] & ~elig[0];
`endif
            is_wr     = g_any & wr[g];
            is_rd     = g_any & rd[g] & ~wr[g];
            exp_rdy   = g_any ? (g ? 2'b10 : 2'b01) : 2'b00;
            exp_addr  = g_any ? ad[g] : 32'h0;
            exp_wdata = g_any ? wd[g] : 32'h0;
            exp_mask  = g_any ? sm[g] : 4'h0;
            exp_rv    = 2'b00;
            exp_err   = 2'b00;
            if (busy == 1) begin
                exp_rv[owner_m]  = 1'b1;
                exp_err[owner_m] = err_m;
                held[owner_m]    = data_m;
            end
            vecs++;
            if (rdy !== exp_rdy || mem_memwrite !== is_wr || mem_memread !== is_rd) begin
                errs++;
                $display("FAIL rand_grant cyc=%0d: ready=%b wr=%b rd=%b want %b %b %b",
                         cyc, rdy, mem_memwrite, mem_memread, exp_rdy, is_wr, is_rd);
            end
            vecs++;
            if (mem_addr !== exp_addr || mem_write_data !== exp_wdata || mem_sign_mask !== exp_mask) begin
                errs++;
                $display("FAIL rand_cmd cyc=%0d: addr=%h wdata=%h mask=%h want %h %h %h",
                         cyc, mem_addr, mem_write_data, mem_sign_mask, exp_addr, exp_wdata, exp_mask);
            end
            vecs++;
            if (rv !== exp_rv || rerr !== exp_err || rdat[0] !== held[0] || rdat[1] !== held[1]) begin
                errs++;
                $display("FAIL rand_resp cyc=%0d: rvalid=%b rerr=%b rdata=%h/%h want %b %b %h/%h",
                         cyc, rv, rerr, rdat[0], rdat[1], exp_rv, exp_err, held[0], held[1]);
            end
            if (busy > 0) busy--;
            if (g_any) begin
                ptr_m = ~g;
                if (is_wr) begin
                    ref_mem[ad[g][5:2]] = wd[g];
                    ref_wr[ad[g][5:2]]  = 1'b1;
                end else begin
                    err_m   = (stall_len == 0) || (stall_len > 15);
                    busy    = (stall_len == 0) ? 16 : ((stall_len <= 15) ? int'(stall_len) + 2 : 17);
                    owner_m = g;
                    data_m  = err_m ? 32'h0 : (ref_wr[ad[g][5:2]] ? ref_mem[ad[g][5:2]] : fill(ad[g]));
                end
            end
            next_cycle();
            if (g_any) v[g] = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_contention();
        test_read_blocks_write();
        test_timeout();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter STALL_TIMEOUT, default 15, max cycles in each read-wait state before abort.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have, per requester n in {0,1}: reqN_valid in 1, reqN_read in 1, reqN_write in 1, reqN_addr in 32, reqN_wdata in 32, reqN_sign_mask in 4.
REQ-005 SHALL have, per requester: reqN_ready out 1 (command accepted), reqN_rvalid out 1 (read done), reqN_rdata out 32, reqN_rerr out 1 (timeout).
REQ-006 SHALL have memory-side ports: mem_addr out 32, mem_write_data out 32, mem_memread out 1, mem_memwrite out 1, mem_sign_mask out 4, mem_read_data in 32, mem_clk_stall in 1.

Function
REQ-007 SHALL implement states IDLE, RD_STALL, RD_DATA, RESP.
REQ-008 In IDLE with mem_clk_stall=0 and any reqN_valid: SHALL grant one requester, drive its command on mem_* combinationally for that cycle, and assert its reqN_ready for exactly that cycle.
REQ-009 No command, and no reqN_ready, SHALL be issued while mem_clk_stall=1.
REQ-010 mem_memread, mem_memwrite, and every reqN_ready SHALL be 0 outside a grant cycle; mem_addr, mem_write_data, mem_sign_mask SHALL be 0 when not granting.
REQ-011 Granted write: SHALL pulse mem_memwrite for 1 cycle and stay in IDLE; back-to-back writes SHALL be issuable on consecutive cycles.
REQ-012 Granted read: SHALL pulse mem_memread for 1 cycle, latch the grant index, and go to RD_STALL.
REQ-013 RD_STALL: on mem_clk_stall=1 SHALL go to RD_DATA.
REQ-014 RD_DATA: on mem_clk_stall=0 SHALL go to RESP.
REQ-015 RESP: SHALL assert rvalid of the latched requester for 1 cycle with rdata=mem_read_data and rerr=0, then return to IDLE; no new grant in RESP.
REQ-016 Nominal read: grant at cycle T, rvalid at cycle T+3.
REQ-017 A requester whose reqN_read and reqN_write are both 1 SHALL be treated as a write only.
REQ-018 A 4-bit wait counter SHALL clear on entry to RD_STALL and RD_DATA; on reaching STALL_TIMEOUT it SHALL go to RESP with rerr=1 and rdata=0.
REQ-019 reqN_rdata SHALL hold its last value between rvalid pulses; the non-granted requester's rvalid SHALL stay 0.
REQ-020 A requester SHALL hold valid and command stable until ready; the arbiter SHALL not buffer commands.

Reset
REQ-021 Reset SHALL force IDLE, zero the counter, set all reqN_ready/rvalid/rerr/rdata to 0, and set the priority pointer to requester 0.
REQ-022 Reset during RD_STALL or RD_DATA SHALL drop the pending response; the first new grant SHALL wait until mem_clk_stall=0, because the memory block has no reset.

Configuration
REQ-023 With DATA_MEM_ARB_RR_EN defined: round-robin arbitration; the pointer SHALL move to the other requester after each grant, and ties SHALL go to the pointer.
REQ-024 Without DATA_MEM_ARB_RR_EN: fixed priority, requester 0 always wins ties; no pointer register SHALL be synthesised.

Structure
REQ-025 State encodings, the STALL_TIMEOUT default, and the memory-command width constants SHALL live in the shared processor package.
REQ-026 A sub-module arb2_grant (2-way grant logic, fixed or round-robin) SHALL be used; the FSM and counter SHALL stay in data_mem_arbiter.

Verification
REQ-027 Single read: req0 read addr 0x10, memory model stalls 1 cycle, data 0xDEADBEEF -> req0_ready at T, req0_rvalid at T+3, req0_rdata=0xDEADBEEF, rerr=0.
REQ-028 Simultaneous write req0 and req1 for 4 cycles, RR defined -> grants alternate 0,1,0,1, one mem_memwrite per cycle; RR undefined -> req0 granted all 4 cycles.
REQ-029 Read req1 addr 0x20 while req0 write pending -> no grant during RD_STALL/RD_DATA/RESP; req0 write granted the cycle after req1_rvalid.
REQ-030 Memory model never asserts mem_clk_stall -> req0_rvalid with rerr=1, rdata=0 after 15 wait cycles, then IDLE.
REQ-031 Reset in RD_DATA with mem_clk_stall=1 held 2 more cycles -> no rvalid, outputs 0, next grant only once mem_clk_stall=0.
